// File: rtl/waveform_capture_buffer_pkg.sv
// Shared constants, state encoding and trigger helper for the waveform capture buffer.
package waveform_capture_buffer_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int DISP_DEPTH   = 640;
  localparam int DISP_AW      = 10;
  localparam int AUTO_TMO_DEF = 2000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cap_state_e;

  // Unsigned rising crossing; a sample equal to the level counts once the previous one was below.
  function automatic logic rising_cross(input logic                prev_valid,
                                        input logic [SAMPLE_W-1:0] prev,
                                        input logic [SAMPLE_W-1:0] cur,
                                        input logic [SAMPLE_W-1:0] level);
    return prev_valid && (prev < level) && (cur >= level);
  endfunction

endpackage

// File: rtl/waveform_capture_buffer_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read-first read port.
module waveform_capture_buffer_dpram
  import waveform_capture_buffer_pkg::*;
#(
  parameter int DEPTH = DISP_DEPTH,
  parameter int AW    = DISP_AW,
  parameter int DW    = SAMPLE_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < AW'(DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; non-blocking semantics give the old word on a same-address write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {DW{1'b0}};
    end else if (raddr_i < AW'(DEPTH)) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= {DW{1'b0}};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/waveform_capture_buffer.sv
// Triggered single-frame capture of the 20 kHz sample stream with scope-style
// normal / auto-timeout / freeze behaviour and a random-access display read port.
module waveform_capture_buffer
  import waveform_capture_buffer_pkg::*;
#(
  parameter int DEPTH        = DISP_DEPTH,
  parameter int AW           = DISP_AW,
  parameter int DW           = SAMPLE_W,
  parameter int AUTO_TIMEOUT = AUTO_TMO_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cs,
  input  logic [DW-1:0] sample,
  input  logic          trig_en,
  input  logic [DW-1:0] trig_level,
  input  logic          freeze,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    state,
  output logic          capture_done,
  output logic          auto_trig
);

  localparam int TW = $clog2(AUTO_TIMEOUT);

  logic          cs_s1_q, cs_s2_q, cs_s3_q;
  logic          stb_s;
  cap_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0] prev_q;
  logic          prev_valid_q;
  logic          capture_done_q, capture_done_d;
  logic          auto_trig_q, auto_trig_d;
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic          cross_s, tmo_hit_s, trig_s;

  // cs synchroniser plus one extra stage for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_s1_q <= 1'b0;
      cs_s2_q <= 1'b0;
      cs_s3_q <= 1'b0;
    end else begin
      cs_s1_q <= cs;
      cs_s2_q <= cs_s1_q;
      cs_s3_q <= cs_s2_q;
    end
  end

  assign stb_s = cs_s2_q & ~cs_s3_q;

  // Previous-sample history for the crossing test, updated on every strobe in every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q       <= {DW{1'b0}};
      prev_valid_q <= 1'b0;
    end else if (stb_s) begin
      prev_q       <= sample;
      prev_valid_q <= 1'b1;
    end else begin
      prev_q       <= prev_q;
      prev_valid_q <= prev_valid_q;
    end
  end

  assign cross_s   = rising_cross(prev_valid_q, prev_q, sample, trig_level);
  assign tmo_hit_s = (tmo_cnt_q == TW'(AUTO_TIMEOUT - 1));
  assign trig_s    = !trig_en || cross_s || tmo_hit_s;

  // Next-state, write-port and flag logic; everything except IDLE advances on strobes only.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    tmo_cnt_d      = tmo_cnt_q;
    capture_done_d = 1'b0;
    auto_trig_d    = auto_trig_q;
    we_s           = 1'b0;
    waddr_s        = wr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_ARMED;
        wr_ptr_d  = {AW{1'b0}};
        tmo_cnt_d = {TW{1'b0}};
      end
      ST_ARMED: begin
        if (stb_s && trig_s) begin
          we_s        = 1'b1;
          waddr_s     = {AW{1'b0}};
          wr_ptr_d    = AW'(1);
          tmo_cnt_d   = {TW{1'b0}};
          // Flag a forced frame only when neither free-run nor a real crossing caused it.
          auto_trig_d = trig_en && !cross_s && tmo_hit_s;
          state_d     = ST_CAPTURE;
        end else if (stb_s) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      ST_CAPTURE: begin
        if (stb_s) begin
          we_s    = 1'b1;
          waddr_s = wr_ptr_q;
          if (wr_ptr_q == AW'(DEPTH - 1)) begin
            wr_ptr_d       = {AW{1'b0}};
            capture_done_d = 1'b1;
            state_d        = ST_HOLD;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_HOLD: begin
        if (stb_s && !freeze) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= {AW{1'b0}};
      tmo_cnt_q      <= {TW{1'b0}};
      capture_done_q <= 1'b0;
      auto_trig_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      tmo_cnt_q      <= tmo_cnt_d;
      capture_done_q <= capture_done_d;
      auto_trig_q    <= auto_trig_d;
    end
  end

  waveform_capture_buffer_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (we_s && !RST),
    .waddr_i (waddr_s),
    .wdata_i (sample),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign state        = state_q;
  assign capture_done = capture_done_q;
  assign auto_trig    = auto_trig_q;

endmodule

// File: tb/tb_waveform_capture_buffer.sv
// Directed self-checking bench for waveform_capture_buffer, using a fast cs (6 CLK per strobe).
module tb_waveform_capture_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cs;
  logic [11:0] sample;
  logic        trig_en;
  logic [11:0] trig_level;
  logic        freeze;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic [1:0]  state;
  logic        capture_done;
  logic        auto_trig;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  waveform_capture_buffer dut (
    .CLK          (CLK),
    .RST          (RST),
    .cs           (cs),
    .sample       (sample),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .freeze       (freeze),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .state        (state),
    .capture_done (capture_done),
    .auto_trig    (auto_trig)
  );

  always #5 CLK = ~CLK;

  // Counts CLK cycles with capture_done high, so a count of one per frame also proves the pulse width.
  always @(posedge CLK) begin
    if (capture_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cs period: the strobe acts on the 3rd rising edge after cs rises; returns at a negedge.
  task automatic strobe(input logic [11:0] v);
    @(negedge CLK);
    sample = v;
    cs = 1'b1;
    repeat (3) @(negedge CLK);
    cs = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [11:0] exp);
    @(negedge CLK);
    rd_addr = a;
    @(negedge CLK);
    chk(tag, {20'd0, rd_data}, {20'd0, exp});
  endtask

  initial begin
    int saved_done;
    logic [11:0] exp_w;

    RST = 1'b1; cs = 1'b0; sample = 12'h000; trig_en = 1'b0;
    trig_level = 12'h800; freeze = 1'b0; rd_addr = 10'd0;
    repeat (5) @(negedge CLK);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_rd_data", {20'd0, rd_data}, 32'd0);
    chk("rst_done", {31'd0, capture_done}, 32'd0);
    chk("rst_auto", {31'd0, auto_trig}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("armed_after_rst", {30'd0, state}, 32'd1);

    // Free-run ramp frame
    for (int k = 0; k < 639; k++) strobe(12'(k));
    chk("fr_still_capture", {30'd0, state}, 32'd2);
    chk("fr_no_done_yet", done_cnt, 32'd0);
    strobe(12'd639);
    chk("fr_hold", {30'd0, state}, 32'd3);
    chk("fr_done_once", done_cnt, 32'd1);
    repeat (20) @(negedge CLK);
    chk("fr_hold_no_cs", {30'd0, state}, 32'd3);
    @(negedge CLK);
    rd_addr = 10'd0;
    for (int a = 1; a <= 640; a++) begin
      @(negedge CLK);
      chk($sformatf("fr_ramp[%0d]", a - 1), {20'd0, rd_data}, 32'(a - 1));
      if (a < 640) rd_addr = 10'(a);
    end
    rd_chk("fr_last", 10'd639, 12'd639);
    rd_chk("fr_oob_700", 10'd700, 12'h000);

    // Threshold trigger
    trig_en = 1'b1;
    trig_level = 12'h800;
    strobe(12'h900);
    chk("thr_rearm", {30'd0, state}, 32'd1);
    strobe(12'h700);
    chk("thr_falling_no_trig", {30'd0, state}, 32'd1);
    strobe(12'h7FF);
    chk("thr_below_no_trig", {30'd0, state}, 32'd1);
    strobe(12'h800);
    chk("thr_equal_trig", {30'd0, state}, 32'd2);
    chk("thr_auto0", {31'd0, auto_trig}, 32'd0);
    strobe(12'h900);
    rd_chk("thr_ram0", 10'd0, 12'h800);
    rd_chk("thr_ram1", 10'd1, 12'h900);
    rd_chk("thr_ram2_old", 10'd2, 12'd2);

    // Reset mid-capture
    for (int k = 0; k < 10; k++) strobe(12'h555);
    saved_done = done_cnt;
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_rd_data", {20'd0, rd_data}, 32'd0);
    chk("mid_rst_done", {31'd0, capture_done}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_armed", {30'd0, state}, 32'd1);
    chk("mid_rst_no_done", done_cnt, 32'(saved_done));
    rd_chk("partial_ram0", 10'd0, 12'h800);
    rd_chk("partial_ram2", 10'd2, 12'h555);
    rd_chk("partial_ram12_old", 10'd12, 12'd12);

    // Auto-timeout
    for (int k = 0; k < 1999; k++) strobe(12'h100);
    chk("tmo_1999_armed", {30'd0, state}, 32'd1);
    strobe(12'h100);
    chk("tmo_2000_capture", {30'd0, state}, 32'd2);
    chk("tmo_auto1", {31'd0, auto_trig}, 32'd1);
    rd_chk("tmo_ram0", 10'd0, 12'h100);

    // Freeze raised mid-capture
    for (int a = 1; a < 640; a++) begin
      if (a == 300) freeze = 1'b1;
      strobe(12'(12'h400 + a));
    end
    chk("frz_hold", {30'd0, state}, 32'd3);
    chk("frz_done", done_cnt, 32'(saved_done + 1));
    for (int k = 0; k < 5000; k++) strobe(12'hFFF);
    chk("frz_hold_5000", {30'd0, state}, 32'd3);
    chk("frz_no_extra_done", done_cnt, 32'(saved_done + 1));
    chk("frz_auto_held", {31'd0, auto_trig}, 32'd1);
    @(negedge CLK);
    rd_addr = 10'd0;
    for (int a = 1; a <= 640; a++) begin
      @(negedge CLK);
      exp_w = (a == 1) ? 12'h100 : 12'(12'h400 + (a - 1));
      chk($sformatf("frz_ram[%0d]", a - 1), {20'd0, rd_data}, {20'd0, exp_w});
      if (a < 640) rd_addr = 10'(a);
    end
    freeze = 1'b0;
    strobe(12'h000);
    chk("unfreeze_armed", {30'd0, state}, 32'd1);
    chk("unfreeze_auto_kept", {31'd0, auto_trig}, 32'd1);
    trig_en = 1'b0;
    strobe(12'h123);
    chk("freerun_retrig", {30'd0, state}, 32'd2);
    chk("freerun_auto0", {31'd0, auto_trig}, 32'd0);
    rd_chk("retrig_ram0", 10'd0, 12'h123);
    rd_chk("retrig_ram1_old", 10'd1, 12'h401);
    rd_chk("retrig_oob", 10'd700, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
